// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma stream controller.
// Provides the letter-code width, the ASCII bytes the controller recognises
// or emits, the controller state encoding, and helpers that convert
// between ASCII letters and 0..25 letter codes.
package enigma_pkg;

    localparam int CODE_W = 5;

    localparam logic [7:0] ASCII_LF      = 8'd10;
    localparam logic [7:0] ASCII_CR      = 8'd13;
    localparam logic [7:0] ASCII_ESC     = 8'd27;
    localparam logic [7:0] ASCII_SPACE   = 8'd32;
    localparam logic [7:0] ASCII_BANG    = 8'd33;
    localparam logic [7:0] ASCII_A       = 8'd65;
    localparam logic [7:0] ASCII_Z       = 8'd90;
    localparam logic [7:0] ASCII_LOWER_A = 8'd97;
    localparam logic [7:0] ASCII_LOWER_Z = 8'd122;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_CHECK  = 3'd2,
        S_STEP   = 3'd3,
        S_ENCODE = 3'd4,
        S_SEP    = 3'd5,
        S_CFG    = 3'd6
    } state_t;

    // True for 'A'..'Z' and 'a'..'z'.
    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= ASCII_A) && (b <= ASCII_Z)) ||
               ((b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z));
    endfunction

    // Letter to code, case folded by clearing bit 5 (only valid for letters).
    function automatic logic [CODE_W-1:0] to_code(input logic [7:0] b);
        logic [7:0] upper;
        upper = b & 8'hDF;
        return CODE_W'(upper - ASCII_A);
    endfunction

    // Code 0..25 back to an upper-case ASCII letter.
    function automatic logic [7:0] to_ascii(input logic [CODE_W-1:0] code);
        return ASCII_A + {3'b000, code};
    endfunction

endpackage

// File: rtl/enigma_stream_controller_fifo.sv
// byte_fifo: synchronous byte FIFO with fall-through head.
// Ports:
//   i_clock, i_reset_n : clock, asynchronous active-low reset (empties FIFO)
//   i_push, i_data     : write a byte (ignored when full)
//   i_pop              : remove the head byte (ignored when empty)
//   o_data, o_valid    : head byte (0 when empty) and not-empty flag
//   o_free             : number of free entries
module byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_push,
    input  logic [7:0]  i_data,
    input  logic        i_pop,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic [AW:0] o_free
);

    localparam int PW = AW + 1;
    localparam logic [AW:0] DEPTH_L = PW'(DEPTH);

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] count_s;
    logic        full_s;
    logic        do_push_s;
    logic        do_pop_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count_s   = wr_ptr_r - rd_ptr_r;
    assign full_s    = (count_s == DEPTH_L);
    assign o_valid   = (count_s != {PW{1'b0}});
    assign o_free    = DEPTH_L - count_s;
    assign do_push_s = i_push & ~full_s;
    assign do_pop_s  = i_pop & o_valid;
    assign o_data    = o_valid ? mem_r[rd_ptr_r[AW-1:0]] : 8'h00;

    // Read/write pointer registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge i_clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/enigma_stream_controller.sv
// enigma_stream_controller: ASCII stream front-end for a combinational
// Enigma cipher core. Letters are stepped and encoded one at a time,
// ciphertext is grouped with space/CR separators, "!" followed by
// NUM_ROTORS letters sets the rotor start positions, ESC reloads the core.
// Ports:
//   i_clock, i_reset_n             : clock, asynchronous active-low reset
//   i_rx_valid/i_rx_data/o_rx_ready: input byte handshake
//   o_tx_valid/o_tx_data/i_tx_ready: output byte handshake (FIFO head)
//   o_code, i_cipher_code          : letter code to core, ciphered code back
//   o_step, o_core_load            : one-cycle rotor step / start-load pulses
//   o_rotor_start                  : start positions, slot 0 in MSBs
//   o_char_count                   : saturating letters since last load
module enigma_stream_controller
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS  = 3,
    parameter int GROUP_SIZE  = 5,
    parameter int LINE_GROUPS = 6,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_rx_valid,
    input  logic [7:0]                   i_rx_data,
    output logic                         o_rx_ready,
    output logic                         o_tx_valid,
    output logic [7:0]                   o_tx_data,
    input  logic                         i_tx_ready,
    output logic [CODE_W-1:0]            o_code,
    input  logic [CODE_W-1:0]            i_cipher_code,
    output logic                         o_step,
    output logic                         o_core_load,
    output logic [CODE_W*NUM_ROTORS-1:0] o_rotor_start,
    output logic [15:0]                  o_char_count
);

    localparam int ROT_W   = CODE_W * NUM_ROTORS;
    localparam int IDX_W   = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int FREE_W  = FIFO_AW + 1;

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_ROTORS - 1);
    localparam logic [7:0]        GROUP_LAST = 8'(GROUP_SIZE - 1);
    localparam logic [7:0]        LINE_LAST  = 8'(LINE_GROUPS - 1);
    // A letter can push a ciphertext byte plus a separator, so two slots
    // must be free before any byte is accepted.
    localparam logic [FREE_W-1:0] FREE_MIN   = FREE_W'(2);

    state_t              state_r, state_s;
    logic [7:0]          byte_r, byte_s;
    logic [CODE_W-1:0]   code_r, code_s;
    logic                step_r, step_s;
    logic                load_r, load_s;
    logic [ROT_W-1:0]    rotor_r, rotor_s;
    logic [ROT_W-1:0]    shadow_r, shadow_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [7:0]          group_r, group_s;
    logic [7:0]          line_r, line_s;
    logic [15:0]         count_r, count_s;

    logic                push_s;
    logic [7:0]          push_data_s;
    logic                pop_s;
    logic [FREE_W-1:0]   free_s;
    logic                accept_s;
    logic [CODE_W-1:0]   cfg_code_s;

    assign o_rx_ready    = ((state_r == S_IDLE) || (state_r == S_CFG)) && (free_s >= FREE_MIN);
    assign accept_s      = i_rx_valid & o_rx_ready;
    assign pop_s         = o_tx_valid & i_tx_ready;
    assign cfg_code_s    = to_code(i_rx_data);
    assign o_code        = code_r;
    assign o_step        = step_r;
    assign o_core_load   = load_r;
    assign o_rotor_start = rotor_r;
    assign o_char_count  = count_r;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_push    (push_s),
        .i_data    (push_data_s),
        .i_pop     (pop_s),
        .o_data    (o_tx_data),
        .o_valid   (o_tx_valid),
        .o_free    (free_s)
    );

    // Next-state, datapath and FIFO-push decode.
    always_comb begin
        state_s     = state_r;
        byte_s      = byte_r;
        code_s      = code_r;
        step_s      = 1'b0;
        load_s      = 1'b0;
        rotor_s     = rotor_r;
        shadow_s    = shadow_r;
        idx_s       = idx_r;
        group_s     = group_r;
        line_s      = line_r;
        count_s     = count_r;
        push_s      = 1'b0;
        push_data_s = 8'h00;

        case (state_r)
            S_INIT: begin
                load_s  = 1'b1;
                state_s = S_IDLE;
            end
            S_IDLE: begin
                if (accept_s) begin
                    byte_s  = i_rx_data;
                    state_s = S_CHECK;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CHECK: begin
                if (is_letter(byte_r)) begin
                    code_s  = to_code(byte_r);
                    // Registered, so the pulse lands on the S_STEP cycle.
                    step_s  = 1'b1;
                    state_s = S_STEP;
                end else if (byte_r == ASCII_ESC) begin
                    push_s      = 1'b1;
                    push_data_s = ASCII_LF;
                    group_s     = 8'd0;
                    line_s      = 8'd0;
                    count_s     = 16'd0;
                    load_s      = 1'b1;
                    state_s     = S_IDLE;
                end else if (byte_r == ASCII_CR) begin
                    push_s      = 1'b1;
                    push_data_s = ASCII_CR;
                    group_s     = 8'd0;
                    line_s      = 8'd0;
                    state_s     = S_IDLE;
                end else if (byte_r == ASCII_BANG) begin
                    idx_s   = {IDX_W{1'b0}};
                    state_s = S_CFG;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_STEP: begin
                state_s = S_ENCODE;
            end
            S_ENCODE: begin
                // Core has stepped at the previous edge; its output is settled.
                push_s      = 1'b1;
                push_data_s = to_ascii(i_cipher_code);
                count_s     = (count_r == 16'hFFFF) ? count_r : (count_r + 16'd1);
                if ((GROUP_SIZE != 0) && (group_r == GROUP_LAST)) begin
                    group_s = 8'd0;
                    state_s = S_SEP;
                end else begin
                    group_s = group_r + 8'd1;
                    state_s = S_IDLE;
                end
            end
            S_SEP: begin
                push_s = 1'b1;
                if ((LINE_GROUPS != 0) && (line_r == LINE_LAST)) begin
                    push_data_s = ASCII_CR;
                    line_s      = 8'd0;
                end else begin
                    push_data_s = ASCII_SPACE;
                    line_s      = line_r + 8'd1;
                end
                state_s = S_IDLE;
            end
            S_CFG: begin
                if (accept_s) begin
                    if (is_letter(i_rx_data)) begin
                        for (int i = 0; i < NUM_ROTORS; i++) begin
                            shadow_s[(NUM_ROTORS-1-i)*CODE_W +: CODE_W] =
                                (idx_r == IDX_W'(i)) ? cfg_code_s
                                                     : shadow_r[(NUM_ROTORS-1-i)*CODE_W +: CODE_W];
                        end
                        if (idx_r == IDX_LAST) begin
                            rotor_s     = shadow_s;
                            load_s      = 1'b1;
                            group_s     = 8'd0;
                            line_s      = 8'd0;
                            count_s     = 16'd0;
                            push_s      = 1'b1;
                            push_data_s = ASCII_LF;
                            state_s     = S_IDLE;
                        end else begin
                            idx_s   = idx_r + IDX_W'(1);
                            state_s = S_CFG;
                        end
                    end else begin
                        // Any non-letter abandons the partial configuration.
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_CFG;
                end
            end
            default: begin
                state_s = S_INIT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r  <= S_INIT;
            byte_r   <= 8'h00;
            code_r   <= {CODE_W{1'b0}};
            step_r   <= 1'b0;
            load_r   <= 1'b0;
            rotor_r  <= {ROT_W{1'b0}};
            shadow_r <= {ROT_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            group_r  <= 8'd0;
            line_r   <= 8'd0;
            count_r  <= 16'd0;
        end else begin
            state_r  <= state_s;
            byte_r   <= byte_s;
            code_r   <= code_s;
            step_r   <= step_s;
            load_r   <= load_s;
            rotor_r  <= rotor_s;
            shadow_r <= shadow_s;
            idx_r    <= idx_s;
            group_r  <= group_s;
            line_r   <= line_s;
            count_r  <= count_s;
        end
    end

endmodule
